// File: rtl/ide_pkg.sv
// Shared definitions for the IDE transfer sequencer: interface register map,
// iocontrol encodings, sequencer states and the bus request record.
package ide_pkg;

  localparam logic [9:0] REG_STATUS       = 10'd0;
  localparam logic [9:0] REG_IOCTRL       = 10'd2;
  localparam logic [9:0] REG_IOPOS        = 10'd3;
  localparam logic [9:0] REG_STATUS_NOIRQ = 10'd4;
  localparam logic [9:0] REG_IOTARGET     = 10'd5;
  localparam logic [9:0] REG_FLAGS        = 10'd6;

  localparam int FLAG_DATA = 5;

  localparam logic [7:0] IOCTRL_OFF = 8'h00;
  localparam logic [7:0] IOCTRL_PIO = 8'h02;
  localparam logic [7:0] IOCTRL_DMA = 8'h04;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CHUNK,
    S_FILL,
    S_SET_POS,
    S_SET_TGT,
    S_SET_CTRL,
    S_SET_STAT,
    S_WAIT_DATA,
    S_ACK,
    S_FINISH,
    S_ABORT,
    S_DONE
  } xfer_state_t;

  typedef struct packed {
    logic       cs;
    logic       oe;
    logic       we;
    logic [9:0] a;
    logic [7:0] d;
  } bus_req_t;

  function automatic bus_req_t bus_wr(input logic [9:0] a, input logic [7:0] d);
    bus_req_t r;
    r.cs = 1'b1;
    r.oe = 1'b0;
    r.we = 1'b1;
    r.a  = a;
    r.d  = d;
    return r;
  endfunction

  function automatic bus_req_t bus_rd(input logic [9:0] a);
    bus_req_t r;
    r.cs = 1'b1;
    r.oe = 1'b1;
    r.we = 1'b0;
    r.a  = a;
    r.d  = 8'h00;
    return r;
  endfunction

endpackage

// File: rtl/ide_bus_arbiter.sv
// CPU / sequencer mux onto the interface register+buffer port. The CPU always
// wins; the sequencer only completes an access on a cycle it owns with no wait.
module ide_bus_arbiter
  import ide_pkg::*;
(
  input  bus_req_t cpu_req,
  input  bus_req_t seq_req,
  input  logic     ide_wait,
  output bus_req_t ide_req,
  output logic     cpu_wait,
  output logic     seq_gnt,
  output logic     seq_done
);

  always_comb begin
    ide_req = seq_req;
    if (cpu_req.cs) ide_req = cpu_req;
  end

  assign cpu_wait = cpu_req.cs & ide_wait;
  assign seq_gnt  = ~cpu_req.cs;
  assign seq_done = seq_req.cs & ~cpu_req.cs & ~ide_wait;

endmodule

// File: rtl/ide_xfer_sequencer.sv
// Device-to-host transfer sequencer: fills the IDE data buffer chunk by chunk,
// arms PIO/DMA, waits for the host data event, acks it and posts final status.
module ide_xfer_sequencer
  import ide_pkg::*;
#(
  parameter logic [7:0] DRQ_STATUS  = 8'h58,
  parameter logic [7:0] END_STATUS  = 8'h50,
  parameter int         CHUNK_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        job_start,
  input  logic [15:0] job_words,
  input  logic        job_dma,
  input  logic        job_abort,
  output logic        job_busy,
  output logic        job_done,
  output logic        job_aborted,
  input  logic [7:0]  src_data,
  input  logic        src_valid,
  output logic        src_ready,
  input  logic [9:0]  cpu_a,
  input  logic [7:0]  cpu_d_in,
  output logic [7:0]  cpu_d_out,
  input  logic        cpu_cs,
  input  logic        cpu_oe,
  input  logic        cpu_we,
  output logic        cpu_wait,
  output logic [9:0]  ide_a,
  output logic [7:0]  ide_d_out,
  input  logic [7:0]  ide_d_in,
  output logic        ide_cs,
  output logic        ide_oe,
  output logic        ide_we,
  input  logic        ide_wait,
  input  logic        ide_irq
);

  localparam logic [15:0] CHUNK_W16 = 16'(CHUNK_WORDS);
  localparam logic [8:0]  CHUNK_W9  = 9'(CHUNK_WORDS);

  xfer_state_t state, state_nx;
  logic [15:0] remaining;
  logic [8:0]  chunk_n;
  logic [9:0]  idx;
  logic        dma;
  logic        aborted;

  bus_req_t    cpu_req, seq_req, ide_req;
  logic        seq_gnt, seq_done;
  logic [8:0]  chunk_len;
  logic        src_acc;
  logic        fill_last;
  logic        abort_go;

  assign cpu_req.cs = cpu_cs;
  assign cpu_req.oe = cpu_oe;
  assign cpu_req.we = cpu_we;
  assign cpu_req.a  = cpu_a;
  assign cpu_req.d  = cpu_d_in;

  ide_bus_arbiter u_arb (
    .cpu_req  (cpu_req),
    .seq_req  (seq_req),
    .ide_wait (ide_wait),
    .ide_req  (ide_req),
    .cpu_wait (cpu_wait),
    .seq_gnt  (seq_gnt),
    .seq_done (seq_done)
  );

  assign ide_cs    = ide_req.cs;
  assign ide_oe    = ide_req.oe;
  assign ide_we    = ide_req.we;
  assign ide_a     = ide_req.a;
  assign ide_d_out = ide_req.d;
  assign cpu_d_out = ide_d_in;

  assign chunk_len = (remaining > CHUNK_W16) ? CHUNK_W9 : remaining[8:0];
  assign src_acc   = src_valid & src_ready;
  assign fill_last = (idx == ({chunk_n, 1'b0} - 10'd1));

  assign job_busy    = (state != S_IDLE);
  assign job_done    = (state == S_DONE);
  assign job_aborted = aborted;

  always_comb begin
    state_nx  = state;
    seq_req   = '0;
    src_ready = 1'b0;
    abort_go  = 1'b0;
    case (state)
      S_IDLE:
        if (job_start) state_nx = (job_words == 16'd0) ? S_FINISH : S_CHUNK;
      S_CHUNK: state_nx = S_FILL;
      S_FILL: begin
        src_ready = seq_gnt & ~ide_wait;
        if (src_valid) seq_req = bus_wr({1'b1, idx[8:0]}, src_data);
        if (src_acc && fill_last) state_nx = S_SET_POS;
      end
      S_SET_POS: begin
        seq_req = bus_wr(REG_IOPOS, 8'h00);
        if (seq_done) state_nx = S_SET_TGT;
      end
      S_SET_TGT: begin
        // 256-word chunk wraps to 8'hFF, matching the 8-bit iotarget register
        seq_req = bus_wr(REG_IOTARGET, 8'(chunk_n - 9'd1));
        if (seq_done) state_nx = S_SET_CTRL;
      end
      S_SET_CTRL: begin
        seq_req = bus_wr(REG_IOCTRL, dma ? IOCTRL_DMA : IOCTRL_PIO);
        if (seq_done) state_nx = S_SET_STAT;
      end
      S_SET_STAT: begin
        seq_req = bus_wr(dma ? REG_STATUS_NOIRQ : REG_STATUS, DRQ_STATUS);
        if (seq_done) state_nx = S_WAIT_DATA;
      end
      S_WAIT_DATA:
        if (ide_irq) begin
          seq_req = bus_rd(REG_FLAGS);
          if (seq_done && ide_d_in[FLAG_DATA]) state_nx = S_ACK;
        end
      S_ACK: begin
        seq_req = bus_wr(REG_FLAGS, 8'h01 << FLAG_DATA);
        if (seq_done) state_nx = (remaining == 16'(chunk_n)) ? S_FINISH : S_CHUNK;
      end
      S_FINISH: begin
        seq_req = bus_wr(REG_STATUS, END_STATUS);
        if (seq_done) state_nx = S_DONE;
      end
      S_ABORT: begin
        seq_req = bus_wr(REG_IOCTRL, IOCTRL_OFF);
        if (seq_done) state_nx = S_DONE;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    // Already-aborting and completing states are left to run their one step out.
    if (job_abort && state != S_IDLE && state != S_ABORT && state != S_DONE) begin
      state_nx = S_ABORT;
      abort_go = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      remaining <= '0;
      chunk_n   <= '0;
      idx       <= '0;
      dma       <= 1'b0;
      aborted   <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE:
          if (job_start) begin
            remaining <= job_words;
            dma       <= job_dma;
            aborted   <= 1'b0;
          end
        S_CHUNK: begin
          chunk_n <= chunk_len;
          idx     <= '0;
        end
        S_FILL: if (src_acc) idx <= idx + 10'd1;
        S_ACK:  if (seq_done) remaining <= remaining - 16'(chunk_n);
        default: ;
      endcase
      if (abort_go) aborted <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ide_xfer_sequencer.sv
// Scoreboard bench for ide_xfer_sequencer: expected interface writes are queued
// at stimulus time and popped as the sequencer issues them on the bus.
module tb_ide_xfer_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        job_start = 1'b0, job_dma = 1'b0, job_abort = 1'b0;
  logic [15:0] job_words = '0;
  logic        job_busy, job_done, job_aborted;
  logic [7:0]  src_data = '0;
  logic        src_valid = 1'b0, src_ready;
  logic [9:0]  cpu_a = 10'd6;
  logic [7:0]  cpu_d_in = 8'h00, cpu_d_out;
  logic        cpu_cs = 1'b0, cpu_oe = 1'b0, cpu_we = 1'b0, cpu_wait;
  logic [9:0]  ide_a;
  logic [7:0]  ide_d_out, ide_d_in;
  logic        ide_cs, ide_oe, ide_we;
  logic        ide_wait = 1'b0, ide_irq = 1'b0;

  ide_xfer_sequencer dut (
    .clk(clk), .rst(rst),
    .job_start(job_start), .job_words(job_words), .job_dma(job_dma), .job_abort(job_abort),
    .job_busy(job_busy), .job_done(job_done), .job_aborted(job_aborted),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
    .cpu_a(cpu_a), .cpu_d_in(cpu_d_in), .cpu_d_out(cpu_d_out),
    .cpu_cs(cpu_cs), .cpu_oe(cpu_oe), .cpu_we(cpu_we), .cpu_wait(cpu_wait),
    .ide_a(ide_a), .ide_d_out(ide_d_out), .ide_d_in(ide_d_in),
    .ide_cs(ide_cs), .ide_oe(ide_oe), .ide_we(ide_we),
    .ide_wait(ide_wait), .ide_irq(ide_irq)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [17:0] exp_q[$];   // {addr, data} of every sequencer write, in order
  logic [7:0]  src_q[$];
  int  cyc = 0, start_cyc = 0, done_cyc = 0, done_cnt = 0, srdy_cnt = 0;
  bit  prev_done = 0, ev_drq = 0, ev_ack = 0, model_flag = 0;
  bit  no_irq = 0, wait_rand = 0, cpu_mode = 0;
  int  irq_delay = 0;

  // Interface model: data flag rises a few cycles after a DRQ status write,
  // with ide_irq asserted one cycle early to exercise the "flag still clear" read.
  assign ide_d_in = (ide_a == 10'd6) ? {2'b00, model_flag, 5'b00000} : 8'hA5;

  initial forever begin
    @(posedge clk); #1;
    cyc++;
    if (rst) begin
      model_flag = 0;
      irq_delay  = 0;
    end else begin
      if (ev_ack) model_flag = 0;
      if (ev_drq && !no_irq) irq_delay = 3;
      else if (irq_delay > 0) begin
        irq_delay--;
        if (irq_delay == 0) model_flag = 1;
      end
    end
    ide_irq   = model_flag || (irq_delay == 1);
    ide_wait  = wait_rand && ($urandom_range(3) == 0);
    cpu_cs    = cpu_mode && !cpu_cs;
    cpu_oe    = cpu_cs;
    src_valid = (src_q.size() > 0);
    src_data  = src_valid ? src_q[0] : 8'h00;
  end

  initial forever begin
    @(negedge clk);
    ev_drq = 0;
    ev_ack = 0;
    if (ide_cs && ide_we && !cpu_cs && !ide_wait) begin
      if (exp_q.size() == 0) chk("bus_wr_extra", {14'h0, ide_a, ide_d_out}, 32'hFFFF_FFFF);
      else chk("bus_wr", {14'h0, ide_a, ide_d_out}, {14'h0, exp_q.pop_front()});
      if ((ide_a == 10'd0 || ide_a == 10'd4) && ide_d_out == 8'h58) ev_drq = 1;
      if (ide_a == 10'd6 && ide_d_out[5]) ev_ack = 1;
    end
    if (src_valid && src_ready && src_q.size() > 0) void'(src_q.pop_front());
    if (src_ready) srdy_cnt++;
    if (cpu_cs) begin
      chk("cpu_rd_data", cpu_d_out, model_flag ? 8'h20 : 8'h00);
      chk("cpu_route", {ide_cs, ide_oe, ide_we, ide_a}, {3'b110, 10'd6});
      chk("cpu_wait", cpu_wait, ide_wait);
    end
    if (job_done) begin
      chk("done_width", prev_done, 0);
      done_cnt++;
      done_cyc = cyc;
    end
    prev_done = job_done;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic push_job(input int words, input bit dma, input bit rnd, input bit stop_stat);
    int rem, n, b;
    logic [7:0] v;
    rem = words;
    b = 0;
    while (rem > 0) begin
      n = (rem > 256) ? 256 : rem;
      for (int i = 0; i < 2 * n; i++) begin
        v = rnd ? 8'($urandom) : 8'(b);
        src_q.push_back(v);
        exp_q.push_back({10'h200 + 10'(i), v});
        b++;
      end
      exp_q.push_back({10'd3, 8'h00});
      exp_q.push_back({10'd5, 8'(n - 1)});
      exp_q.push_back({10'd2, dma ? 8'h04 : 8'h02});
      exp_q.push_back({dma ? 10'd4 : 10'd0, 8'h58});
      if (stop_stat) return;
      exp_q.push_back({10'd6, 8'h20});
      rem -= n;
    end
    exp_q.push_back({10'd0, 8'h50});
  endtask

  task automatic start_job(input logic [15:0] w, input bit dma, input bit with_abort);
    @(posedge clk); #2;
    job_words = w;
    job_dma   = dma;
    job_start = 1;
    job_abort = with_abort;
    @(negedge clk);
    start_cyc = cyc;
    @(posedge clk); #2;
    job_start = 0;
    job_abort = 0;
    @(negedge clk);
    chk("busy_after_start", job_busy, 1);
  endtask

  task automatic wait_done(input int bound);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < bound && done_cnt == d0; i++) @(negedge clk);
    chk("done_seen", done_cnt - d0, 1);
  endtask

  task automatic wait_sb_empty(input string tag, input int bound);
    for (int i = 0; i < bound && exp_q.size() != 0; i++) @(negedge clk);
    chk(tag, exp_q.size(), 0);
  endtask

  initial begin
    int first, last, cnt, s0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", {job_busy, job_done, job_aborted, src_ready, ide_cs, ide_oe, ide_we, cpu_wait}, 8'h00);
    @(posedge clk); #2 rst = 0;

    // PIO, 4 words, bytes 00..07
    push_job(4, 0, 0, 0);
    start_job(16'd4, 0, 0);
    wait_done(400);
    wait_sb_empty("pio4_sb", 5);
    chk("pio4_src_left", src_q.size(), 0);
    chk("pio4_not_aborted", job_aborted, 0);

    // DMA, 300 words with random interface wait states: 256 + 44 word chunks
    wait_rand = 1;
    push_job(300, 1, 1, 0);
    start_job(16'd300, 1, 0);
    wait_done(5000);
    wait_rand = 0;
    wait_sb_empty("dma300_sb", 5);
    chk("dma300_src_left", src_q.size(), 0);

    // Zero-length job
    s0 = srdy_cnt;
    push_job(0, 0, 0, 0);
    start_job(16'd0, 0, 0);
    wait_done(20);
    chk("zero_latency", done_cyc - start_cyc, 2);
    chk("zero_src_ready", srdy_cnt - s0, 0);
    wait_sb_empty("zero_sb", 5);

    // CPU reading flags every other cycle during the fill
    cpu_mode = 1;
    push_job(8, 0, 1, 0);
    start_job(16'd8, 0, 0);
    first = 0; last = 0; cnt = 0;
    for (int i = 0; i < 400 && cnt < 16; i++) begin
      @(negedge clk);
      if (src_valid && src_ready) begin
        if (cnt == 0) first = cyc;
        last = cyc;
        cnt++;
      end
    end
    cpu_mode = 0;
    chk("cpu_fill_bytes", cnt, 16);
    chk("cpu_fill_span", last - first + 1, 31);
    wait_done(400);
    wait_sb_empty("cpu_sb", 5);

    // Abort while waiting for the data event
    no_irq = 1;
    push_job(2, 0, 1, 1);
    start_job(16'd2, 0, 0);
    wait_sb_empty("abort_pre_sb", 200);
    repeat (3) @(negedge clk);
    chk("abort_wait_busy", job_busy, 1);
    exp_q.push_back({10'd2, 8'h00});
    @(posedge clk); #2 job_abort = 1;
    @(posedge clk); #2 job_abort = 0;
    wait_done(20);
    chk("abort_flag", job_aborted, 1);
    wait_sb_empty("abort_sb", 5);
    @(negedge clk);
    chk("abort_idle", job_busy, 0);
    no_irq = 0;

    // New job with start and abort together in IDLE: start wins
    push_job(1, 0, 1, 0);
    start_job(16'd1, 0, 1);
    chk("abort_cleared", job_aborted, 0);
    wait_done(200);
    wait_sb_empty("start_wins_sb", 5);

    // Reset in the middle of a fill, then a clean 2-word job
    push_job(4, 0, 1, 0);
    start_job(16'd4, 0, 0);
    for (int i = 0; i < 100 && src_q.size() > 5; i++) @(negedge clk);
    chk("rst_mid_fill_reached", src_q.size() <= 5, 1);
    @(posedge clk); #2 rst = 1;
    @(posedge clk); #2 rst = 0;
    src_q.delete();
    exp_q.delete();
    @(negedge clk);
    chk("rst_mid_outs", {job_busy, job_done, job_aborted, src_ready, ide_cs, ide_oe, ide_we, cpu_wait}, 8'h00);
    push_job(2, 0, 0, 0);
    start_job(16'd2, 0, 0);
    wait_done(200);
    wait_sb_empty("post_rst_sb", 5);
    chk("post_rst_src_left", src_q.size(), 0);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/ide_xfer_sequencer.md
Name: ide_xfer_sequencer

Overview:
- Hardware sequencer for the device-to-host data path of the IDE interface block. It moves a sector stream into the 512-byte IDE data buffer and arms the interface for PIO or DMA.
- Large transfers are split into chunks of up to 256 words. For each chunk it waits for the interface "data" event, acknowledges it, and finally posts the completion status.
- It sits between the AVR SRAM-style bus and the IDE interface register/buffer port, and shares that port with the CPU.

Parameters:
- DRQ_STATUS, 8'h58, status byte posted when a chunk is ready (DRDY|DSC|DRQ).
- END_STATUS, 8'h50, status byte posted at job completion (DRDY|DSC).
- CHUNK_WORDS, 256, maximum words per chunk; must be ≤256.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- job_start  in  1  one-cycle pulse; ignored while job_busy
- job_words  in  16  total 16-bit words to transfer; sampled on job_start
- job_dma  in  1  1 = DMA, 0 = PIO; sampled on job_start
- job_abort  in  1  one-cycle abort request
- job_busy  out  1  job in progress
- job_done  out  1  one-cycle pulse on completion or abort
- job_aborted  out  1  held high from abort until next job_start
- src_data  in  8  source byte stream
- src_valid  in  1  src_data valid
- src_ready  out  1  byte accepted when src_valid&src_ready
- cpu_a  in  10  CPU address
- cpu_d_in  in  8  CPU write data
- cpu_d_out  out  8  CPU read data (ide_d_in passthrough)
- cpu_cs, cpu_oe, cpu_we  in  1  CPU strobes
- cpu_wait  out  1  CPU wait
- ide_a  out  10  to interface sram_a
- ide_d_out  out  8  to interface sram_d_in
- ide_d_in  in  8  from interface sram_d_out
- ide_cs, ide_oe, ide_we  out  1  to interface strobes
- ide_wait  in  1  interface sram_wait
- ide_irq  in  1  interface cpu_irq

Behaviour:
- Reset: state IDLE; job_busy, job_done, job_aborted, src_ready, ide_cs/oe/we, cpu_wait = 0; counters = 0.
- Interface map used:
  - reg 0: status write, raises host IRQ.
  - reg 2: iocontrol (bit1 PIO, bit2 DMA, bit0 = 0 for bus reads).
  - reg 3: iopos.
  - reg 4: status write without IRQ.
  - reg 5: iotarget.
  - reg 6: flags; read bit5 = data; write 1 to bit5 clears it.
  - Buffer: a[9]=1, byte address a[8:0]; even address = low byte.
- Arbitration (combinational, per cycle):
  - CPU wins whenever cpu_cs=1: ide_* = cpu_*, cpu_wait = ide_wait, and the sequencer access is stalled that cycle (no state advance, src_ready=0).
  - When cpu_cs=0, the sequencer drives ide_*.
  - CPU accesses during a job are the firmware's responsibility.
- Access completion: a sequencer access completes in the cycle it is granted with ide_wait=0. Reads sample ide_d_in in that same cycle.
- FSM:
  - IDLE: on job_start, latch words/dma, set job_busy, clear job_aborted. Go to FINISH if words==0, else CHUNK.
  - CHUNK: n = min(remaining, CHUNK_WORDS); byte index = 0 → FILL.
  - FILL: src_ready = granted & ~ide_wait. Each accepted byte writes buffer address {1, idx[8:0]}; idx++. After 2n bytes → SET_POS. Throughput is 1 byte/cycle when unblocked.
  - SET_POS: write reg3 = 0 → SET_TGT.
  - SET_TGT: write reg5 = n-1 (8 bits; n=256 gives 8'hFF) → SET_CTRL.
  - SET_CTRL: write reg2 = 8'h02 (PIO) or 8'h04 (DMA) → SET_STAT.
  - SET_STAT: PIO writes reg0 = DRQ_STATUS; DMA writes reg4 = DRQ_STATUS → WAIT_DATA.
  - WAIT_DATA: idle until ide_irq=1, then read reg6. If bit5=1 → ACK; else stay.
  - ACK: write reg6 = 8'h20; remaining -= n. Go to FINISH if remaining==0, else CHUNK.
  - FINISH: write reg0 = END_STATUS → DONE.
  - DONE: pulse job_done, clear job_busy → IDLE.
- Abort: job_abort in any non-IDLE state → ABORT. ABORT writes reg2 = 0, then goes to DONE with job_aborted=1. job_abort in IDLE is ignored.
- Simultaneous job_start and job_abort in IDLE: start wins.
- Remaining count is 16-bit, so up to 65535 words → 256 chunks. The last chunk may be partial.

Decomposition:
- Shared package ide_pkg:
  - interface register address constants (REG_STATUS=0, REG_IOCTRL=2, REG_IOPOS=3, REG_STATUS_NOIRQ=4, REG_IOTARGET=5, REG_FLAGS=6);
  - flag bit positions (FLAG_DATA=5);
  - iocontrol encodings;
  - FSM state enum.
- One sub-module: ide_bus_arbiter, the combinational CPU/sequencer mux producing ide_* strobes, cpu_wait and the sequencer grant.

Test Plan:
- PIO, job_words=4, src bytes 00..07 → buffer writes a=0x200..0x207, then reg3=00, reg5=03, reg2=02, reg0=58. Model sets data flag + irq → reg6 write 20, reg0 write 50, job_done pulse.
- DMA, job_words=300 → chunk 1: 512 bytes, reg5=FF, reg2=04, reg4=58. Chunk 2: 88 bytes, reg5=2B. Exactly one reg0 write (50).
- job_words=0 → single reg0=50 write, job_done 2 cycles after start, src_ready never high.
- CPU reads reg6 every other cycle during FILL → CPU always served same cycle; fill takes 2× cycles; no byte lost or duplicated.
- job_abort in WAIT_DATA → reg2=00 written, job_done pulse, job_aborted=1, then IDLE accepts new job_start.
- rst asserted mid-FILL → next cycle all outputs 0, state IDLE; subsequent 2-word job completes normally.
